// File: rtl/lvds_word_packer_pkg.sv
// Shared helpers for the LVDS word packer: samples-per-word, byte-enable masks, parameter legality.
package lvds_pkg;

  localparam int unsigned BE_MAX = 64;

  function automatic int unsigned calc_k(input int unsigned data_len, input int unsigned lvds_len);
    return data_len / lvds_len;
  endfunction

  // Low-ones byte-enable mask covering nbytes bytes.
  function automatic logic [BE_MAX-1:0] be_mask(input int unsigned nbytes);
    if (nbytes >= BE_MAX) return '1;
    return (BE_MAX'(1) << nbytes) - BE_MAX'(1);
  endfunction

  function automatic bit params_ok(input int unsigned lvds_len, input int unsigned data_len,
                                   input int unsigned be_len, input int unsigned depth,
                                   input bit ts_en);
    bit ok;
    ok = (lvds_len > 0) && (lvds_len % 8 == 0) && (data_len >= lvds_len);
    ok = ok && (data_len % lvds_len == 0) && (be_len == data_len / 8) && (be_len <= BE_MAX);
    ok = ok && (depth >= 2) && ((depth & (depth - 1)) == 0);
    // A header and a data push may only never coincide when a word takes at least two samples.
    ok = ok && (!ts_en || (data_len / lvds_len >= 2));
    return ok;
  endfunction

endpackage

// File: rtl/lvds_word_packer_sync_fifo_fwft.sv
// Single-clock first-word-fall-through queue; head word and valid are registered outputs.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             pop_ok, push_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_ok  = pop && valid_q;
  assign push_ok = push && (!full || pop_ok);

  // Next head: the word being pushed when it lands exactly in the new head slot, else storage.
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    valid_d  = (count_d != '0);
    dout_d   = dout_q;
    if (count_d != '0) begin
      dout_d = (push_ok && (rd_ptr_d == wr_ptr_q)) ? din : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = dout_q;
  assign valid = valid_q;

endmodule

// File: rtl/lvds_word_packer.sv
// Packs LVDS samples into byte-enabled words with burst-end flush and an FWFT output queue.
// Optional timestamp header words per burst when LVDS_PACKER_TS_EN is defined.
module lvds_word_packer
  import lvds_pkg::*;
#(
  parameter int unsigned LVDS_LEN  = 8,
  parameter int unsigned DATA_LEN  = 32,
  parameter int unsigned BE_LEN    = 4,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_in,
  input  logic [LVDS_LEN-1:0] data_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] out_data,
  output logic [BE_LEN-1:0]   out_be,
  output logic                out_hdr,
  output logic                overflow,
  input  logic                ovf_clr
);

  localparam int unsigned K             = calc_k(DATA_LEN, LVDS_LEN);
  localparam int unsigned CNT_W         = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned Q_W           = DATA_LEN + BE_LEN + 1;
  localparam int unsigned BYTES_PER_SMP = LVDS_LEN / 8;
`ifdef LVDS_PACKER_TS_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  if (!params_ok(LVDS_LEN, DATA_LEN, BE_LEN, OUT_DEPTH, TS_EN)) begin : g_bad_params
    $error("lvds_word_packer: illegal parameter combination");
  end

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                prev_valid_q, prev_valid_d;
  logic [DATA_LEN-1:0] acc_q, acc_d;
  logic                overflow_q, overflow_d;
  logic [31:0]         shamt_c;
  logic                push_c, pop_c, drop_c;
  logic [Q_W-1:0]      push_word_c;
  logic [Q_W-1:0]      head_word;
  logic                fifo_full, fifo_empty;
`ifdef LVDS_PACKER_TS_EN
  logic [DATA_LEN-1:0] ts_q, ts_d;
`endif

  assign shamt_c = 32'(cnt_q) * LVDS_LEN;
  assign pop_c   = out_ready && !fifo_empty;
  assign drop_c  = push_c && fifo_full && !pop_c;

  // Accumulate samples, push full words, flush a partial word on the falling edge of valid_in.
  always_comb begin
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    prev_valid_d = valid_in;
    push_c       = 1'b0;
    push_word_c  = '0;
    if (valid_in) begin
      if (cnt_q == '0) acc_d = DATA_LEN'(data_in);
      else             acc_d = acc_q | (DATA_LEN'(data_in) << shamt_c);
      if (cnt_q == CNT_W'(K - 1)) begin
        push_c      = 1'b1;
        push_word_c = {1'b0, {BE_LEN{1'b1}}, acc_d};
        cnt_d       = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (prev_valid_q && (cnt_q != '0)) begin
      push_c      = 1'b1;
      push_word_c = {1'b0, BE_LEN'(be_mask(32'(cnt_q) * BYTES_PER_SMP)), acc_q};
      cnt_d       = '0;
    end
`ifdef LVDS_PACKER_TS_EN
    // cnt is 0 at any burst start and K >= 2, so this never displaces a data push.
    if (valid_in && !prev_valid_q) begin
      push_c      = 1'b1;
      push_word_c = {1'b1, {BE_LEN{1'b1}}, ts_q};
    end
`endif
    overflow_d = drop_c | (overflow_q & ~ovf_clr);
  end

`ifdef LVDS_PACKER_TS_EN
  assign ts_d = ts_q + DATA_LEN'(1);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      acc_q        <= '0;
      prev_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef LVDS_PACKER_TS_EN
      ts_q         <= '0;
`endif
    end else begin
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      prev_valid_q <= prev_valid_d;
      overflow_q   <= overflow_d;
`ifdef LVDS_PACKER_TS_EN
      ts_q         <= ts_d;
`endif
    end
  end

  sync_fifo_fwft #(
    .WIDTH (Q_W),
    .DEPTH (OUT_DEPTH)
  ) u_out_q (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .din   (push_word_c),
    .pop   (pop_c),
    .dout  (head_word),
    .valid (out_valid),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_hdr  = head_word[Q_W-1];
  assign out_be   = head_word[DATA_LEN +: BE_LEN];
  assign out_data = head_word[DATA_LEN-1:0];
  assign overflow = overflow_q;

endmodule

// File: tb/tb_lvds_word_packer.sv
// Bench for lvds_word_packer: directed vector table, corner sequences, and random traffic vs a queue model.
module tb_lvds_word_packer;

  localparam int unsigned LVDS_LEN  = 8;
  localparam int unsigned DATA_LEN  = 32;
  localparam int unsigned BE_LEN    = 4;
  localparam int unsigned OUT_DEPTH = 4;
  localparam int unsigned K         = DATA_LEN / LVDS_LEN;

  logic        clk = 1'b0;
  logic        rst, valid_in, out_ready, ovf_clr;
  logic [7:0]  data_in;
  logic        out_valid, out_hdr, overflow;
  logic [31:0] out_data;
  logic [3:0]  out_be;

  always #5 clk = ~clk;

  lvds_word_packer #(
    .LVDS_LEN (LVDS_LEN),
    .DATA_LEN (DATA_LEN),
    .BE_LEN   (BE_LEN),
    .OUT_DEPTH(OUT_DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .data_in  (data_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_be   (out_be),
    .out_hdr  (out_hdr),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  typedef struct {
    logic [31:0] d;
    logic [3:0]  be;
    logic        hdr;
  } word_t;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        ev;
    logic [31:0] ed;
    logic [3:0]  ebe;
  } vec_t;

  // Reference model state: queue contents, pending samples, last shown head.
  word_t       mq[$];
  word_t       m_last;
  logic [7:0]  m_smp[$];
  logic        m_prev, m_ovf;
  logic [31:0] m_ts;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_smp.delete();
    m_prev = 1'b0;
    m_ovf  = 1'b0;
    m_ts   = '0;
    m_last = '{d: 32'h0, be: 4'h0, hdr: 1'b0};
  endfunction

  function automatic word_t make_word(input int n);
    word_t w;
    w.d   = '0;
    for (int i = 0; i < n; i++) w.d = w.d | (32'(m_smp[i]) << (8 * i));
    w.be  = 4'((1 << n) - 1);
    w.hdr = 1'b0;
    return w;
  endfunction

  task automatic model_check();
    word_t e;
    e = (mq.size() != 0) ? mq[0] : m_last;
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("out_data", 64'(out_data), 64'(e.d));
    chk("out_be", 64'(out_be), 64'(e.be));
    chk("out_hdr", 64'(out_hdr), 64'(e.hdr));
    chk("overflow", 64'(overflow), 64'(m_ovf));
  endtask

  task automatic model_advance(input logic v, input logic [7:0] d, input logic r,
                               input logic c, input logic rs);
    logic  have, pop, drop;
    word_t pw;
    if (rs) begin
      model_reset();
      return;
    end
    have = 1'b0;
    pw   = '{d: 32'h0, be: 4'h0, hdr: 1'b0};
    pop  = (mq.size() != 0) && r;
`ifdef LVDS_PACKER_TS_EN
    if (v && !m_prev) begin
      have = 1'b1;
      pw   = '{d: m_ts, be: 4'hF, hdr: 1'b1};
    end
`endif
    if (v) begin
      m_smp.push_back(d);
      if (m_smp.size() == K) begin
        have = 1'b1;
        pw   = make_word(K);
        m_smp.delete();
      end
    end else if (m_prev && m_smp.size() > 0) begin
      have = 1'b1;
      pw   = make_word(m_smp.size());
      m_smp.delete();
    end
    drop = have && (mq.size() == OUT_DEPTH) && !pop;
    if (pop) void'(mq.pop_front());
    if (have && !drop) mq.push_back(pw);
    m_ovf  = drop ? 1'b1 : (c ? 1'b0 : m_ovf);
    m_prev = v;
    m_ts   = m_ts + 32'd1;
    if (mq.size() != 0) m_last = mq[0];
  endtask

  // One clock: drive inputs, check outputs mid-cycle, advance the model, return just after the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic r,
                      input logic c, input logic rs);
    valid_in  = v;
    data_in   = d;
    out_ready = r;
    ovf_clr   = c;
    rst       = rs;
    @(negedge clk);
    model_check();
    model_advance(v, d, r, c, rs);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] wexp(input int j);
    return {8'(4 * j + 4), 8'(4 * j + 3), 8'(4 * j + 2), 8'(4 * j + 1)};
  endfunction

  vec_t tbl[16];
  int   drained;

  initial begin
    tbl[0]  = '{1'b1, 8'h11, 1'b0, 32'h00000000, 4'h0};
    tbl[1]  = '{1'b1, 8'h22, 1'b0, 32'h00000000, 4'h0};
    tbl[2]  = '{1'b1, 8'h33, 1'b0, 32'h00000000, 4'h0};
    tbl[3]  = '{1'b1, 8'h44, 1'b0, 32'h00000000, 4'h0};
    tbl[4]  = '{1'b1, 8'h55, 1'b1, 32'h44332211, 4'hF};
    tbl[5]  = '{1'b1, 8'h66, 1'b0, 32'h44332211, 4'hF};
    tbl[6]  = '{1'b1, 8'h77, 1'b0, 32'h44332211, 4'hF};
    tbl[7]  = '{1'b1, 8'h88, 1'b0, 32'h44332211, 4'hF};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 32'h88776655, 4'hF};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 32'h88776655, 4'hF};
    tbl[10] = '{1'b1, 8'h11, 1'b0, 32'h88776655, 4'hF};
    tbl[11] = '{1'b1, 8'h22, 1'b0, 32'h88776655, 4'hF};
    tbl[12] = '{1'b1, 8'h33, 1'b0, 32'h88776655, 4'hF};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 32'h88776655, 4'hF};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 32'h00332211, 4'h7};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 32'h00332211, 4'h7};

    valid_in  = 1'b0;
    data_in   = '0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;

`ifndef LVDS_PACKER_TS_EN
    // Full words, no partial at word-aligned burst end, then a 3-sample partial.
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d_data", i), 64'(out_data), 64'(tbl[i].ed));
      chk($sformatf("tbl%0d_be", i), 64'(out_be), 64'(tbl[i].ebe));
      step(tbl[i].v, tbl[i].d, 1'b1, 1'b0, 1'b0);
    end

    // Six words into a stalled queue: four kept in order, two dropped, then clear.
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int j = 0; j < 6; j++)
      for (int s = 0; s < 4; s++) step(1'b1, 8'(4 * j + s + 1), 1'b0, 1'b0, 1'b0);
    chk("ovf_set", 64'(overflow), 64'd1);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("drain_w%0d", j), 64'(out_data), 64'(wexp(j)));
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("drain_empty", 64'(out_valid), 64'd0);
    chk("ovf_hold", 64'(overflow), 64'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("ovf_clr", 64'(overflow), 64'd0);

    // Full queue, simultaneous pop and push on the completing sample.
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int j = 0; j < 4; j++)
      for (int s = 0; s < 4; s++) step(1'b1, 8'(4 * j + s + 1), 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 3; s++) step(1'b1, 8'(16 + s + 1), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'(20), 1'b1, 1'b0, 1'b0);
    chk("pp_ovf", 64'(overflow), 64'd0);
    drained = 0;
    for (int j = 1; j <= 5; j++) begin
      if (out_valid) begin
        chk($sformatf("pp_w%0d", j), 64'(out_data), 64'(wexp(j)));
        drained++;
      end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("pp_count", 64'(drained), 64'd4);

    // Reset mid-burst with queued words.
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int s = 0; s < 10; s++) step(1'b1, 8'(s + 1), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    for (int s = 0; s < 4; s++) step(1'b1, 8'(8'hA1 + s), 1'b1, 1'b0, 1'b0);
    chk("rst_new_valid", 64'(out_valid), 64'd1);
    chk("rst_new_data", 64'(out_data), 64'h00000000A4A3A2A1);
    chk("rst_new_be", 64'(out_be), 64'hF);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`else
    // Burst starting at timestamp 10 gets a header before its data.
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    chk("hdr_valid", 64'(out_valid), 64'd1);
    chk("hdr_data", 64'(out_data), 64'h0000000A);
    chk("hdr_flag", 64'(out_hdr), 64'd1);
    chk("hdr_be", 64'(out_be), 64'hF);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("ts_data_valid", 64'(out_valid), 64'd1);
    chk("ts_data", 64'(out_data), 64'h44332211);
    chk("ts_data_hdr", 64'(out_hdr), 64'd0);
`endif

    // Random traffic with phased backpressure, occasional clears and resets.
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      logic v, r, c, rs;
      int   rdy_pct;
      rdy_pct = ((i / 200) % 2 == 0) ? 90 : 20;
      v  = ($urandom_range(0, 99) < 70);
      r  = ($urandom_range(0, 99) < rdy_pct);
      c  = ($urandom_range(0, 99) < 5);
      rs = ($urandom_range(0, 999) < 3);
      step(v, 8'($urandom), r, c, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
